// File: rtl/shadow_write_queue_pkg.sv
// Shared types and helpers for the shadow-memory posted-write queue.
package shadow_write_queue_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        PUSH_NONE,
        PUSH_MERGE,
        PUSH_APPEND,
        PUSH_DROP
    } push_class_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/shadow_write_queue_if.sv
// Bus-side write strobes, SDRAM client request port and queue status.
interface shadow_write_queue_if #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 21
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                  wr_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [7:0]            data_i;
    logic [3:0]            byte_en_i;

    logic                  mem_wr_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_data_o;
    logic [3:0]            mem_byte_en_o;
    logic                  mem_ready_i;

    logic [LVL_W-1:0]      level_o;
    logic                  full_o;
    logic                  empty_o;
    logic [15:0]           drop_count_o;

    modport master (
        output wr_i, addr_i, data_i, byte_en_i, mem_ready_i,
        input  mem_wr_o, mem_addr_o, mem_data_o, mem_byte_en_o,
        input  level_o, full_o, empty_o, drop_count_o
    );

    modport slave (
        input  wr_i, addr_i, data_i, byte_en_i, mem_ready_i,
        output mem_wr_o, mem_addr_o, mem_data_o, mem_byte_en_o,
        output level_o, full_o, empty_o, drop_count_o
    );

endinterface

// File: rtl/shadow_write_queue_entry_merge.sv
// Combinational lane merge: enabled lanes take the new byte, the rest keep
// the old entry's data; lane enables accumulate.
module queue_entry_merge
    import shadow_write_queue_pkg::*;
(
    input  logic [31:0]      old_data,
    input  logic [LANES-1:0] old_byte_en,
    input  logic [7:0]       byte_i,
    input  logic [LANES-1:0] en_i,
    output logic [31:0]      new_data,
    output logic [LANES-1:0] new_byte_en
);

    always_comb begin
        new_data    = old_data;
        new_byte_en = old_byte_en | en_i;
        for (int l = 0; l < LANES; l++) begin
            if (en_i[l]) begin
                new_data[8*l +: 8] = byte_i;
            end
        end
    end

endmodule

// File: rtl/shadow_write_queue.sv
// Posted-write FIFO between the Apple II shadow logic and one SDRAM client
// port: absorbs controller stalls, merges same-word writes, counts drops.
module shadow_write_queue
    import shadow_write_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 21
) (
    input  logic             clk_logic,
    input  logic             system_reset,
    shadow_write_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
        logic [LANES-1:0]      byte_en;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [LVL_W-1:0] level;
    logic [15:0]      drop_count;

    logic             full;
    logic             empty;
    logic             pop;
    logic             wr_valid;
    push_class_e      push_class;

    logic [31:0]      base_data;
    logic [LANES-1:0] base_be;
    logic [LANES-1:0] merge_en;
    logic [31:0]      merged_data;
    logic [LANES-1:0] merged_be;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign tail_ptr = wr_ptr - PTR_W'(1);
    assign pop      = !empty && bus.mem_ready_i;
    assign wr_valid = bus.wr_i && (bus.byte_en_i != '0);

    // The head is never a merge target: it may be mid-handshake, hence level >= 2.
    always_comb begin
        push_class = PUSH_NONE;
        if (wr_valid) begin
            if ((level >= LVL_W'(2)) && (mem[tail_ptr].addr == bus.addr_i)) begin
                push_class = PUSH_MERGE;
            end else if (!full || pop) begin
                push_class = PUSH_APPEND;
            end else begin
                push_class = PUSH_DROP;
            end
        end
    end

    // A fresh entry starts from zero with the byte replicated into every lane;
    // byte_en alone says which lanes the controller writes.
    always_comb begin
        base_data = '0;
        base_be   = '0;
        merge_en  = '1;
        if (push_class == PUSH_MERGE) begin
            base_data = mem[tail_ptr].data;
            base_be   = mem[tail_ptr].byte_en;
            merge_en  = bus.byte_en_i;
        end
    end

    queue_entry_merge u_merge (
        .old_data    (base_data),
        .old_byte_en (base_be),
        .byte_i      (bus.data_i),
        .en_i        (merge_en),
        .new_data    (merged_data),
        .new_byte_en (merged_be)
    );

    always_ff @(posedge clk_logic or posedge system_reset) begin
        if (system_reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            drop_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case (push_class)
                PUSH_MERGE: begin
                    mem[tail_ptr].data    <= merged_data;
                    mem[tail_ptr].byte_en <= merged_be;
                end
                PUSH_APPEND: begin
                    mem[wr_ptr] <= '{addr: bus.addr_i, data: merged_data, byte_en: bus.byte_en_i};
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                PUSH_DROP: begin
                    drop_count <= sat_inc16(drop_count);
                end
                default: ;
            endcase

            if ((push_class == PUSH_APPEND) && !pop) begin
                level <= level + LVL_W'(1);
            end else if ((push_class != PUSH_APPEND) && pop) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    assign bus.mem_wr_o      = !empty;
    assign bus.mem_addr_o    = mem[rd_ptr].addr;
    assign bus.mem_data_o    = mem[rd_ptr].data;
    assign bus.mem_byte_en_o = mem[rd_ptr].byte_en;
    assign bus.level_o       = level;
    assign bus.full_o        = full;
    assign bus.empty_o       = empty;
    assign bus.drop_count_o  = drop_count;

endmodule

// File: tb/tb_shadow_write_queue.sv
// Scoreboard bench for shadow_write_queue: a queue-based reference model
// tracks expected contents; a negedge monitor compares the DUT against it.
module tb_shadow_write_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 21;

    logic clk_logic    = 1'b0;
    logic system_reset = 1'b1;

    always #5 clk_logic = ~clk_logic;

    shadow_write_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();

    shadow_write_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_logic    (clk_logic),
        .system_reset (system_reset),
        .bus          (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
    } exp_t;

    exp_t model_q[$];
    int   model_drops;
    int   tests = 0;
    int   fails = 0;

    int   m_sz;
    bit   m_pop;
    bit   m_merge;
    exp_t m_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds exactly what the controller should see.
    always @(posedge clk_logic or posedge system_reset) begin
        if (system_reset) begin
            model_q.delete();
            model_drops = 0;
        end else begin
            m_sz    = model_q.size();
            m_pop   = (m_sz > 0) && bus.mem_ready_i;
            m_merge = 1'b0;
            if (bus.wr_i && bus.byte_en_i != 4'b0000) begin
                if (m_sz >= 2 && model_q[m_sz-1].addr == bus.addr_i) begin
                    m_merge = 1'b1;
                    m_e = model_q[m_sz-1];
                    for (int l = 0; l < 4; l++)
                        if (bus.byte_en_i[l]) m_e.data[8*l +: 8] = bus.data_i;
                    m_e.be = m_e.be | bus.byte_en_i;
                    model_q[m_sz-1] = m_e;
                end
            end
            if (m_pop) void'(model_q.pop_front());
            if (bus.wr_i && bus.byte_en_i != 4'b0000 && !m_merge) begin
                if (m_sz < DEPTH || m_pop) begin
                    m_e.addr = bus.addr_i;
                    m_e.data = {4{bus.data_i}};
                    m_e.be   = bus.byte_en_i;
                    model_q.push_back(m_e);
                end else if (model_drops < 65535) begin
                    model_drops++;
                end
            end
        end
    end

    // Monitor: outputs depend only on registered state, so negedge is stable.
    always @(negedge clk_logic) begin
        check("level", 64'(bus.level_o), 64'(model_q.size()));
        check("empty", 64'(bus.empty_o), 64'(model_q.size() == 0));
        check("full", 64'(bus.full_o), 64'(model_q.size() == DEPTH));
        check("drop_count", 64'(bus.drop_count_o), 64'(model_drops));
        check("mem_wr", 64'(bus.mem_wr_o), 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            check("head_addr", 64'(bus.mem_addr_o), 64'(model_q[0].addr));
            check("head_data", 64'(bus.mem_data_o), 64'(model_q[0].data));
            check("head_be", 64'(bus.mem_byte_en_o), 64'(model_q[0].be));
        end
    end

    task automatic cyc(input bit wr, input logic [AW-1:0] a, input logic [7:0] d,
                       input logic [3:0] be, input bit rdy);
        @(negedge clk_logic);
        bus.wr_i        = wr;
        bus.addr_i      = a;
        bus.data_i      = d;
        bus.byte_en_i   = be;
        bus.mem_ready_i = rdy;
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, '0, 8'h00, 4'b0000, rdy);
    endtask

    task automatic pulse_reset();
        #2 system_reset = 1'b1;
        #1;
        check("rst_mem_wr", 64'(bus.mem_wr_o), 64'd0);
        check("rst_level", 64'(bus.level_o), 64'd0);
        check("rst_drop", 64'(bus.drop_count_o), 64'd0);
        check("rst_empty", 64'(bus.empty_o), 64'd1);
        #1 system_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_i        = 1'b0;
        bus.addr_i      = '0;
        bus.data_i      = 8'h00;
        bus.byte_en_i   = 4'b0000;
        bus.mem_ready_i = 1'b0;
        repeat (3) @(negedge clk_logic);
        check("reset_empty", 64'(bus.empty_o), 64'd1);
        check("reset_full", 64'(bus.full_o), 64'd0);
        check("reset_mem_wr", 64'(bus.mem_wr_o), 64'd0);
        check("reset_drop", 64'(bus.drop_count_o), 64'd0);
        check("reset_addr", 64'(bus.mem_addr_o), 64'd0);
        check("reset_data", 64'(bus.mem_data_o), 64'd0);
        check("reset_be", 64'(bus.mem_byte_en_o), 64'd0);
        system_reset = 1'b0;

        // Single write with ready held high
        cyc(1'b1, 21'h00200, 8'h5A, 4'b0001, 1'b1);
        idle(1'b1);
        check("single_mem_wr", 64'(bus.mem_wr_o), 64'd1);
        check("single_addr", 64'(bus.mem_addr_o), 64'h200);
        check("single_data", 64'(bus.mem_data_o), 64'h5A5A5A5A);
        check("single_be", 64'(bus.mem_byte_en_o), 64'h1);
        idle(1'b1);
        check("single_gone", 64'(bus.mem_wr_o), 64'd0);
        check("single_level", 64'(bus.level_o), 64'd0);

        // Merge into tail
        cyc(1'b1, 21'h00100, 8'h11, 4'b0001, 1'b0);
        cyc(1'b1, 21'h00200, 8'h22, 4'b0001, 1'b0);
        cyc(1'b1, 21'h00200, 8'h33, 4'b0010, 1'b0);
        idle(1'b0);
        check("merge_level", 64'(bus.level_o), 64'd2);
        idle(1'b1);
        idle(1'b1);
        check("merge_addr", 64'(bus.mem_addr_o), 64'h200);
        check("merge_be", 64'(bus.mem_byte_en_o), 64'h3);
        check("merge_lanes", 64'(bus.mem_data_o[15:0]), 64'h3322);
        idle(1'b1);
        check("merge_drained", 64'(bus.empty_o), 64'd1);

        // Same address at level 1 must not merge into the head
        cyc(1'b1, 21'h00300, 8'hAA, 4'b0001, 1'b0);
        cyc(1'b1, 21'h00300, 8'hBB, 4'b0100, 1'b0);
        idle(1'b0);
        check("nohead_level", 64'(bus.level_o), 64'd2);
        check("nohead_first_be", 64'(bus.mem_byte_en_o), 64'h1);
        idle(1'b1);
        idle(1'b1);
        check("nohead_second_be", 64'(bus.mem_byte_en_o), 64'h4);
        idle(1'b1);

        // Overflow: 10 distinct writes into 8 entries
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 21'(32'h1000 + i), 8'(i), 4'b0001, 1'b0);
        idle(1'b0);
        check("ovf_full", 64'(bus.full_o), 64'd1);
        check("ovf_drop", 64'(bus.drop_count_o), 64'd2);

        // Full with a simultaneous pop
        cyc(1'b1, 21'h02000, 8'h77, 4'b1000, 1'b1);
        idle(1'b0);
        check("fullpop_level", 64'(bus.level_o), 64'd8);
        check("fullpop_drop", 64'(bus.drop_count_o), 64'd2);
        repeat (10) idle(1'b1);
        check("fullpop_drained", 64'(bus.empty_o), 64'd1);

        // Reset mid-operation
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 21'(32'h3000 + 4 * i), 8'(8'h40 + i), 4'b1111, 1'b0);
        idle(1'b0);
        check("pre_rst_level", 64'(bus.level_o), 64'd5);
        pulse_reset();
        cyc(1'b1, 21'h04000, 8'h99, 4'b0010, 1'b1);
        idle(1'b1);
        check("post_rst_addr", 64'(bus.mem_addr_o), 64'h4000);
        check("post_rst_data", 64'(bus.mem_data_o), 64'h99999999);
        idle(1'b1);
        check("post_rst_empty", 64'(bus.empty_o), 64'd1);

        // Randomized traffic over a small address set, varying stall pressure
        for (int phase = 0; phase < 3; phase++) begin
            for (int n = 0; n < 1000; n++) begin
                cyc(($urandom % 4) != 0,
                    21'(32'h500 + $urandom_range(0, 3)),
                    8'($urandom),
                    4'($urandom_range(0, 15)),
                    ($urandom % 4) < phase + 1);
            end
        end
        repeat (20) idle(1'b1);
        check("final_empty", 64'(bus.empty_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
